// File: rtl/pipe_stage_chain_pkg.sv
// Shared definitions for the elastic pipeline chain.
//   NOP_INST   : default NOP encoding for a 16-bit instruction payload.
//   clog2_safe : bit width needed to hold values 0..n-1, never less than 1.
package pipe_pkg;

  localparam logic [15:0] NOP_INST = 16'h0000;

  // A plain $clog2 gives 0 for n<=1. A zero-width counter is illegal, so
  // the result is clamped to at least one bit.
  function automatic int clog2_safe(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// valid/ready/data handshake bundle for one side of the chain.
//   master : drives valid and data, samples ready
//   slave  : samples valid and data, drives ready
interface pipe_stage_chain_if #(
  parameter int WIDTH = 16
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready;

  modport master (output valid, data, input ready);
  modport slave  (input valid, data, output ready);
endinterface

// File: rtl/pipe_stage_chain_stage.sv
// pipe_stage: a single elastic register stage (valid bit plus payload).
//   clk, rst    : clock, synchronous active-low reset
//   flush       : clear the stage to an empty NOP
//   load        : capture load_data this edge (the stage becomes valid)
//   load_data   : payload coming from upstream
//   adv         : the stage's content leaves this edge
//   v, d        : registered valid bit and payload
module pipe_stage #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             adv,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  // Drain clears only the valid bit; the payload keeps its last value,
  // so an empty chain still shows its last word on the output.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      v <= 1'b0;
      d <= NOP_VALUE;
    end else if (load) begin
      v <= 1'b1;
      d <= load_data;
    end else if (adv) begin
      v <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH elastic register stages carrying an opaque
// payload. Stall propagates back through a combinational ready chain.
// A flush or reset empties every stage and loads NOP_VALUE.
//   clk, rst  : clock, synchronous active-low reset
//   flush     : discard all in-flight entries
//   up        : upstream handshake (in_valid / in_data / in_ready)
//   dn        : downstream handshake (out_valid / out_data / out_ready)
//   occupancy : number of valid stages, 0..DEPTH
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(NOP_INST)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  pipe_stage_chain_if.slave                   up,
  pipe_stage_chain_if.master                  dn,
  output logic [clog2_safe(DEPTH+1)-1:0]      occupancy
);

  localparam int OW = clog2_safe(DEPTH + 1);

  logic [DEPTH-1:0]            v, adv, load;
  logic [DEPTH-1:0][WIDTH-1:0] d, load_data;
  logic [DEPTH:0]              room;

  // room[i]: stage i can take a new word this edge, because it is empty or
  // its own content moves on. Evaluated from the output side backwards.
  always_comb begin
    adv         = '0;
    room        = '0;
    room[DEPTH] = dn.ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i]  = v[i] & room[i+1];
      room[i] = ~v[i] | adv[i];
    end
  end

  assign up.ready = ~flush & rst & room[0];
  assign dn.valid = v[DEPTH-1] & ~flush;
  assign dn.data  = d[DEPTH-1];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign load[g]      = up.valid & up.ready;
      assign load_data[g] = up.data;
    end else begin : g_body
      assign load[g]      = adv[g-1];
      assign load_data[g] = d[g-1];
    end

    pipe_stage #(
      .WIDTH     (WIDTH),
      .NOP_VALUE (NOP_VALUE)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .load      (load[g]),
      .load_data (load_data[g]),
      .adv       (adv[g]),
      .v         (v[g]),
      .d         (d[g])
    );
  end

  // Internal moves leave the count alone; only entry and exit change it.
  always_ff @(posedge clk) begin
    if (!rst || flush) occupancy <= '0;
    else               occupancy <= occupancy + OW'(load[0]) - OW'(adv[DEPTH-1]);
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
module tb_pipe_stage_chain;
  import pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, flush_a, flush_b;
  logic [1:0] occ_a;
  logic [0:0] occ_b;

  pipe_stage_chain_if #(16) a_up (), a_dn (), b_up (), b_dn ();

  pipe_stage_chain #(.WIDTH(16), .DEPTH(2), .NOP_VALUE(16'h0000)) u_a (
    .clk(clk), .rst(rst), .flush(flush_a), .up(a_up), .dn(a_dn), .occupancy(occ_a));
  pipe_stage_chain #(.WIDTH(16), .DEPTH(1), .NOP_VALUE(16'hFFFF)) u_b (
    .clk(clk), .rst(rst), .flush(flush_b), .up(b_up), .dn(b_dn), .occupancy(occ_b));

  // Behavioural model: slots with valid flags; an entry moves on when any
  // slot ahead of it is free or the consumer takes the head.
  typedef struct packed { logic [1:0] v; logic [1:0][15:0] d; } ms_t;
  typedef struct packed { logic ir; logic ov; logic [15:0] od; logic [2:0] occ; } mo_t;

  ms_t ma, mb;
  int  nt = 0, nf = 0, cyc_n = 0;
  bit  chk_en = 1'b0;
  logic [15:0] a_got[$], b_got[$];
  int          a_cyc[$];
  int          a_maxocc = 0;

  function automatic logic free_ahead(ms_t s, int dep, int from, logic ordy);
    if (ordy) return 1'b1;
    for (int j = from; j < dep; j++) if (!s.v[j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic mo_t outs(ms_t s, int dep, logic r, logic fl, logic ordy);
    mo_t o;
    o.ir  = r & ~fl & free_ahead(s, dep, 0, ordy);
    o.ov  = s.v[dep-1] & ~fl;
    o.od  = s.d[dep-1];
    o.occ = '0;
    for (int j = 0; j < dep; j++) o.occ = o.occ + 3'(s.v[j]);
    return o;
  endfunction

  function automatic ms_t step(ms_t s, int dep, logic [15:0] nop, logic r, logic fl,
                               logic iv, logic [15:0] id, logic ordy);
    ms_t n;
    mo_t o;
    n.v = '0;
    n.d = s.d;
    if (!r || fl) begin
      for (int j = 0; j < 2; j++) n.d[j] = nop;
      return n;
    end
    for (int i = 0; i < dep; i++) begin
      if (s.v[i]) begin
        if (free_ahead(s, dep, i + 1, ordy)) begin
          if (i < dep - 1) begin
            n.v[i+1] = 1'b1;
            n.d[i+1] = s.d[i];
          end
        end else begin
          n.v[i] = 1'b1;
        end
      end
    end
    o = outs(s, dep, r, fl, ordy);
    if (iv && o.ir) begin
      n.v[0] = 1'b1;
      n.d[0] = id;
    end
    return n;
  endfunction

  task automatic chk(string name, int act, int exp);
    nt++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    ma    <= step(ma, 2, 16'h0000, rst, flush_a, a_up.valid, a_up.data, a_dn.ready);
    mb    <= step(mb, 1, 16'hFFFF, rst, flush_b, b_up.valid, b_up.data, b_dn.ready);
    cyc_n <= cyc_n + 1;
  end

  // Per-cycle compare against the model plus delivery logging.
  always @(negedge clk) begin
    mo_t oa, ob;
    if (chk_en) begin
      oa = outs(ma, 2, rst, flush_a, a_dn.ready);
      ob = outs(mb, 1, rst, flush_b, b_dn.ready);
      chk("a_in_ready", a_up.ready, oa.ir);
      chk("a_out_valid", a_dn.valid, oa.ov);
      chk("a_out_data", a_dn.data, oa.od);
      chk("a_occupancy", occ_a, oa.occ);
      chk("b_in_ready", b_up.ready, ob.ir);
      chk("b_out_valid", b_dn.valid, ob.ov);
      chk("b_out_data", b_dn.data, ob.od);
      chk("b_occupancy", occ_b, ob.occ);
    end
    if (a_dn.valid && a_dn.ready) begin
      a_got.push_back(a_dn.data);
      a_cyc.push_back(cyc_n);
    end
    if (b_dn.valid && b_dn.ready) b_got.push_back(b_dn.data);
    if (int'(occ_a) > a_maxocc) a_maxocc = int'(occ_a);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_seq(string nm, logic [15:0] got[$], int n,
                           logic [15:0] e0, logic [15:0] e1, logic [15:0] e2, logic [15:0] e3);
    logic [15:0] e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk({nm, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) chk(nm, got[i], e[i]);
  endtask

  task automatic clear_a();
    a_got.delete();
    a_cyc.delete();
  endtask

  initial begin
    int p0;
    rst = 1'b0; flush_a = 1'b0; flush_b = 1'b0;
    a_up.valid = 1'b0; a_up.data = '0; a_dn.ready = 1'b0;
    b_up.valid = 1'b0; b_up.data = '0; b_dn.ready = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_occ", occ_a, 0);
    chk("rst_out_valid", a_dn.valid, 0);
    chk("rst_out_data", a_dn.data, 16'h0000);
    chk("rst_in_ready_low", a_up.ready, 0);
    chk("rst_b_out_data", b_dn.data, 16'hFFFF);
    rst = 1'b1;
    #1;
    chk("rst_in_ready_high", a_up.ready, 1);
    tick();

    // Stream
    clear_a(); a_maxocc = 0;
    a_dn.ready = 1'b1;
    p0 = cyc_n;
    for (int k = 0; k < 3; k++) begin
      a_up.valid = 1'b1; a_up.data = 16'(16'h1111 * (k + 1));
      #1 chk("stream_in_ready", a_up.ready, 1);
      tick();
    end
    a_up.valid = 1'b0;
    repeat (4) tick();
    check_seq("stream_seq", a_got, 3, 16'h1111, 16'h2222, 16'h3333, 16'h0);
    if (a_cyc.size() >= 3) begin
      chk("stream_latency", a_cyc[0] - p0, 2);
      chk("stream_b2b", a_cyc[2] - a_cyc[0], 2);
    end
    chk("stream_peak_occ", a_maxocc, 2);

    // Backpressure
    clear_a();
    a_dn.ready = 1'b0;
    a_up.valid = 1'b1; a_up.data = 16'hA001; tick();
    a_up.data = 16'hA002; tick();
    a_up.data = 16'hA003;
    repeat (3) begin
      chk("bp_in_ready", a_up.ready, 0);
      chk("bp_out_data", a_dn.data, 16'hA001);
      chk("bp_occ", occ_a, 2);
      tick();
    end
    a_dn.ready = 1'b1;
    #1 chk("bp_full_shift_ready", a_up.ready, 1);
    tick();
    a_up.valid = 1'b0;
    repeat (4) tick();
    check_seq("bp_seq", a_got, 3, 16'hA001, 16'hA002, 16'hA003, 16'h0);

    // Bubble collapse
    clear_a();
    a_dn.ready = 1'b0;
    a_up.valid = 1'b1; a_up.data = 16'hB001; tick();
    a_up.valid = 1'b0; tick();
    a_up.valid = 1'b1; a_up.data = 16'hB002; tick();
    a_up.valid = 1'b0; tick();
    chk("bubble_occ", occ_a, 2);
    a_dn.ready = 1'b1;
    repeat (4) tick();
    check_seq("bubble_seq", a_got, 2, 16'hB001, 16'hB002, 16'h0, 16'h0);
    if (a_cyc.size() >= 2) chk("bubble_consec", a_cyc[1] - a_cyc[0], 1);

    // Flush
    a_dn.ready = 1'b0;
    a_up.valid = 1'b1; a_up.data = 16'hD001; tick();
    a_up.data = 16'hD002; tick();
    clear_a();
    a_dn.ready = 1'b1; flush_a = 1'b1; a_up.data = 16'hC001;
    #1;
    chk("flush_out_valid", a_dn.valid, 0);
    chk("flush_in_ready", a_up.ready, 0);
    tick();
    flush_a = 1'b0; a_up.valid = 1'b0;
    chk("flush_occ", occ_a, 0);
    chk("flush_out_data", a_dn.data, 16'h0000);
    chk("flush_out_valid_after", a_dn.valid, 0);
    repeat (3) tick();
    chk("flush_none_delivered", a_got.size(), 0);

    // Reset mid-operation
    a_dn.ready = 1'b0;
    a_up.valid = 1'b1; a_up.data = 16'hE001; tick();
    a_up.data = 16'hE002; tick();
    a_up.valid = 1'b0;
    rst = 1'b0;
    #1 chk("midrst_in_ready", a_up.ready, 0);
    tick();
    chk("midrst_occ", occ_a, 0);
    chk("midrst_out_valid", a_dn.valid, 0);
    chk("midrst_out_data", a_dn.data, 16'h0000);
    rst = 1'b1;
    clear_a();
    a_dn.ready = 1'b1;
    a_up.valid = 1'b1; a_up.data = 16'hF001;
    #1 chk("postrst_in_ready", a_up.ready, 1);
    tick();
    a_up.data = 16'hF002; tick();
    a_up.valid = 1'b0;
    repeat (4) tick();
    check_seq("postrst_seq", a_got, 2, 16'hF001, 16'hF002, 16'h0, 16'h0);

    // DEPTH=1, NOP=FFFF
    b_got.delete();
    b_dn.ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b_up.valid = 1'b1; b_up.data = 16'(16'h5000 + k);
      #1 chk("d1_in_ready", b_up.ready, 1);
      tick();
    end
    b_up.valid = 1'b0;
    repeat (3) tick();
    check_seq("d1_seq", b_got, 4, 16'h5000, 16'h5001, 16'h5002, 16'h5003);
    b_dn.ready = 1'b0;
    b_up.valid = 1'b1; b_up.data = 16'h6001; tick();
    b_up.valid = 1'b0;
    chk("d1_held_data", b_dn.data, 16'h6001);
    flush_b = 1'b1;
    #1 chk("d1_flush_valid", b_dn.valid, 0);
    tick();
    flush_b = 1'b0;
    chk("d1_flush_data", b_dn.data, 16'hFFFF);
    chk("d1_flush_occ", occ_b, 0);

    // Randomized traffic on both chains, checked cycle by cycle
    repeat (600) begin
      a_up.valid = ($urandom_range(0, 99) < 60);
      a_up.data  = 16'($urandom);
      a_dn.ready = ($urandom_range(0, 99) < 55);
      flush_a    = ($urandom_range(0, 99) < 4);
      b_up.valid = ($urandom_range(0, 99) < 60);
      b_up.data  = 16'($urandom);
      b_dn.ready = ($urandom_range(0, 99) < 55);
      flush_b    = ($urandom_range(0, 99) < 4);
      rst        = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      tick();
    end
    rst = 1'b1; flush_a = 1'b0; flush_b = 1'b0;
    a_up.valid = 1'b0; b_up.valid = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

endmodule
